// File: rtl/scpad_dram_req_splitter_pkg.sv
//----------------------------------------------------------------------------
// Module : scpad_pkg
// Brief  : Shared widths, splitter FSM states and command record.
// Rev    : 1.0 initial release
//----------------------------------------------------------------------------
`default_nettype none

package scpad_pkg;
    localparam int DRAM_ADDR_WIDTH    = 32;
    localparam int DRAM_ID_WIDTH      = 4;
    localparam int COL_IDX_WIDTH      = 7;
    localparam int SPLIT_BEAT_BYTES   = 8;
    localparam int SPLIT_MAX_SUB      = 8;
    localparam int SPLIT_SUB_ID_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_CMPL = 2'd2
    } split_state_t;

    typedef struct packed {
        logic [DRAM_ADDR_WIDTH-1:0] addr;
        logic [DRAM_ID_WIDTH-1:0]   id;
        logic                       write;
        logic [COL_IDX_WIDTH-1:0]   nbytes;
    } split_cmd_t;
endpackage

`default_nettype wire

// File: rtl/scpad_dram_req_splitter_if.sv
//----------------------------------------------------------------------------
// Module : scpad_dram_req_splitter_if
// Brief  : Scheduler command, queue sub-request and completion signals.
// Rev    : 1.0 initial release
//----------------------------------------------------------------------------
`default_nettype none

interface scpad_dram_req_splitter_if;
    import scpad_pkg::*;

    logic                          sched_valid;
    logic                          sched_ready;
    logic                          sched_write;
    logic [DRAM_ADDR_WIDTH-1:0]    sched_addr;
    logic [DRAM_ID_WIDTH-1:0]      sched_id;
    logic [COL_IDX_WIDTH-1:0]      sched_nbytes;
    logic                          be_stall;
    logic                          dram_queue_full;
    logic                          burst_complete;
    logic                          q_valid;
    logic                          q_write;
    logic [DRAM_ADDR_WIDTH-1:0]    q_addr;
    logic [DRAM_ID_WIDTH-1:0]      q_id;
    logic [SPLIT_SUB_ID_WIDTH-1:0] q_sub_id;
    logic [SPLIT_SUB_ID_WIDTH-1:0] q_num_request;
    logic [COL_IDX_WIDTH-1:0]      q_num_bytes;
    logic                          xfer_done;
    logic [DRAM_ID_WIDTH-1:0]      xfer_done_id;

    modport master (
        input  sched_valid, sched_write, sched_addr, sched_id, sched_nbytes,
        input  be_stall, dram_queue_full, burst_complete,
        output sched_ready, q_valid, q_write, q_addr, q_id, q_sub_id,
        output q_num_request, q_num_bytes, xfer_done, xfer_done_id
    );

    modport slave (
        output sched_valid, sched_write, sched_addr, sched_id, sched_nbytes,
        output be_stall, dram_queue_full, burst_complete,
        input  sched_ready, q_valid, q_write, q_addr, q_id, q_sub_id,
        input  q_num_request, q_num_bytes, xfer_done, xfer_done_id
    );
endinterface

`default_nettype wire

// File: rtl/scpad_dram_req_splitter_sat_counter.sv
//----------------------------------------------------------------------------
// Module : scpad_sat_counter
// Brief  : Saturating event counter with synchronous clear.
// Rev    : 1.0 initial release
//----------------------------------------------------------------------------
`default_nettype none

module scpad_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/scpad_dram_req_splitter.sv
//----------------------------------------------------------------------------
// Module : scpad_dram_req_splitter
// Brief  : Splits scheduler row transfers into beat sub-requests for the DRAM
//          queue. SCPAD_SPLIT_PERF_EN adds full-cycle / sub-request counters.
// Rev    : 1.0 initial release
//----------------------------------------------------------------------------
`default_nettype none

module scpad_dram_req_splitter
    import scpad_pkg::*;
#(
    parameter int BEAT_BYTES = SPLIT_BEAT_BYTES,
    parameter int MAX_SUB    = SPLIT_MAX_SUB
) (
    input  logic                       clk,
    input  logic                       rst,
    scpad_dram_req_splitter_if.master  bus
`ifdef SCPAD_SPLIT_PERF_EN
    ,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_sub_reqs
`endif
);
    localparam int                       c_BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [COL_IDX_WIDTH-1:0] c_BEAT       = COL_IDX_WIDTH'(BEAT_BYTES);
    localparam logic [COL_IDX_WIDTH-1:0] c_BEAT_MASK  = COL_IDX_WIDTH'(BEAT_BYTES - 1);
    localparam logic [COL_IDX_WIDTH-1:0] c_MAX_BYTES  = COL_IDX_WIDTH'(MAX_SUB * BEAT_BYTES);

    split_state_t                  r_state, w_state;
    // addr tracks the current sub-request; nbytes holds the tail sub-request size
    split_cmd_t                    r_cmd, w_cmd;
    logic [SPLIT_SUB_ID_WIDTH-1:0] r_sub_id, w_sub_id;
    logic [SPLIT_SUB_ID_WIDTH-1:0] r_num_req, w_num_req;
    logic [COL_IDX_WIDTH-1:0]      r_num_bytes, w_num_bytes;
    logic                          r_done, w_done;
    logic [DRAM_ID_WIDTH-1:0]      r_done_id, w_done_id;

    logic [COL_IDX_WIDTH-1:0]      w_nb_clamp, w_nsub, w_tail;
    logic [SPLIT_SUB_ID_WIDTH-1:0] w_sub_inc;
    logic                          w_hs;

    assign w_nb_clamp = (bus.sched_nbytes > c_MAX_BYTES) ? c_MAX_BYTES : bus.sched_nbytes;
    assign w_nsub     = (w_nb_clamp + c_BEAT_MASK) >> c_BEAT_SHIFT;
    assign w_tail     = ((w_nb_clamp & c_BEAT_MASK) == '0) ? c_BEAT : (w_nb_clamp & c_BEAT_MASK);
    assign w_sub_inc  = r_sub_id + 1'b1;
    assign w_hs       = (r_state == ISSUE) && !bus.dram_queue_full && !bus.be_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_sub_id    <= '0;
            r_num_req   <= '0;
            r_num_bytes <= '0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
        end else begin
            r_state     <= w_state;
            r_cmd       <= w_cmd;
            r_sub_id    <= w_sub_id;
            r_num_req   <= w_num_req;
            r_num_bytes <= w_num_bytes;
            r_done      <= w_done;
            r_done_id   <= w_done_id;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cmd       = r_cmd;
        w_sub_id    = r_sub_id;
        w_num_req   = r_num_req;
        w_num_bytes = r_num_bytes;
        w_done      = 1'b0;
        w_done_id   = r_done_id;
        if (bus.be_stall) begin
            w_done = r_done;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.sched_valid) begin
                        w_cmd.addr  = bus.sched_addr;
                        w_cmd.id    = bus.sched_id;
                        w_cmd.write = bus.sched_write;
                        w_cmd.nbytes = w_tail;
                        w_sub_id    = '0;
                        w_num_req   = SPLIT_SUB_ID_WIDTH'(w_nsub - 7'd1);
                        w_num_bytes = (w_nsub > 7'd1) ? c_BEAT : w_tail;
                        if (w_nsub == '0) begin
                            w_done    = 1'b1;
                            w_done_id = bus.sched_id;
                        end else begin
                            w_state = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!bus.dram_queue_full) begin
                        if (r_sub_id == r_num_req) begin
                            // completion may coincide with the last handshake
                            if (bus.burst_complete) begin
                                w_state   = IDLE;
                                w_done    = 1'b1;
                                w_done_id = r_cmd.id;
                            end else begin
                                w_state = WAIT_CMPL;
                            end
                        end else begin
                            w_sub_id    = w_sub_inc;
                            w_cmd.addr  = r_cmd.addr + DRAM_ADDR_WIDTH'(BEAT_BYTES);
                            w_num_bytes = (w_sub_inc == r_num_req) ? r_cmd.nbytes : c_BEAT;
                        end
                    end
                end
                WAIT_CMPL: begin
                    if (bus.burst_complete) begin
                        w_state   = IDLE;
                        w_done    = 1'b1;
                        w_done_id = r_cmd.id;
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end

    assign bus.sched_ready   = (r_state == IDLE);
    assign bus.q_valid       = (r_state == ISSUE);
    assign bus.q_write       = r_cmd.write;
    assign bus.q_addr        = r_cmd.addr;
    assign bus.q_id          = r_cmd.id;
    assign bus.q_sub_id      = r_sub_id;
    assign bus.q_num_request = r_num_req;
    assign bus.q_num_bytes   = r_num_bytes;
    assign bus.xfer_done     = r_done;
    assign bus.xfer_done_id  = r_done_id;

    a_nbytes_legal: assert property (@(posedge clk) disable iff (rst)
        (bus.sched_valid && bus.sched_ready && !bus.be_stall) |-> (bus.sched_nbytes <= c_MAX_BYTES));

`ifdef SCPAD_SPLIT_PERF_EN
    logic w_full_evt;
    assign w_full_evt = (r_state == ISSUE) && bus.dram_queue_full && !bus.be_stall;

    scpad_sat_counter #(.WIDTH(32)) u_full_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (w_full_evt),
        .count (perf_full_cycles)
    );

    scpad_sat_counter #(.WIDTH(32)) u_sub_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (w_hs),
        .count (perf_sub_reqs)
    );
`endif
endmodule

`default_nettype wire

// File: tb/tb_scpad_dram_req_splitter.sv
//----------------------------------------------------------------------------
// Module : tb_scpad_dram_req_splitter
// Brief  : Directed and random stimulus against a transaction-level model.
// Rev    : 1.0 initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_scpad_dram_req_splitter;
    import scpad_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scpad_dram_req_splitter_if bus();

`ifdef SCPAD_SPLIT_PERF_EN
    logic [31:0] perf_full_cycles;
    logic [31:0] perf_sub_reqs;
`endif

    scpad_dram_req_splitter dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus)
`ifdef SCPAD_SPLIT_PERF_EN
        ,
        .perf_full_cycles (perf_full_cycles),
        .perf_sub_reqs    (perf_sub_reqs)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic        write;
        logic [2:0]  sub_id;
        logic [2:0]  num_req;
        logic [6:0]  nbytes;
    } sub_t;

    sub_t        exp_q[$];
    bit          busy, awaiting, exp_done, chk_en, prev_rst;
    logic [3:0]  exp_done_id, cur_id;
    int unsigned mdl_full, mdl_subs;
    int          total, bad;

    logic        drv_rst, drv_valid, drv_write, drv_full, drv_stall, drv_cmpl;
    logic [31:0] drv_addr;
    logic [3:0]  drv_id;
    logic [6:0]  drv_nbytes;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model
    task automatic cycle();
        sub_t s;
        int   n;
        bit   new_done;
        @(negedge clk);
        if (chk_en) begin
            check("q_valid", bus.q_valid, exp_q.size() != 0);
            check("sched_ready", bus.sched_ready, !busy);
            check("xfer_done", bus.xfer_done, exp_done);
            if (exp_done) check("done_id", bus.xfer_done_id, exp_done_id);
            if (bus.q_valid && exp_q.size() != 0) begin
                s = exp_q[0];
                check("q_addr", bus.q_addr, s.addr);
                check("q_sub_id", bus.q_sub_id, s.sub_id);
                check("q_num_req", bus.q_num_request, s.num_req);
                check("q_num_bytes", bus.q_num_bytes, s.nbytes);
                check("q_id", bus.q_id, s.id);
                check("q_write", bus.q_write, s.write);
            end
            if (prev_rst) begin
                check("rst_q_addr", bus.q_addr, 0);
                check("rst_q_sub_id", bus.q_sub_id, 0);
                check("rst_q_bytes", bus.q_num_bytes, 0);
                check("rst_done_id", bus.xfer_done_id, 0);
            end
`ifdef SCPAD_SPLIT_PERF_EN
            check("perf_full", perf_full_cycles, mdl_full);
            check("perf_subs", perf_sub_reqs, mdl_subs);
`endif
        end
        rst                 = drv_rst;
        bus.sched_valid     = drv_valid;
        bus.sched_write     = drv_write;
        bus.sched_addr      = drv_addr;
        bus.sched_id        = drv_id;
        bus.sched_nbytes    = drv_nbytes;
        bus.dram_queue_full = drv_full;
        bus.be_stall        = drv_stall;
        bus.burst_complete  = drv_cmpl;
        prev_rst            = drv_rst;
        if (drv_rst) begin
            chk_en = 1'b1;
            exp_q.delete();
            busy = 0; awaiting = 0; exp_done = 0;
            mdl_full = 0; mdl_subs = 0;
        end else if (!drv_stall) begin
            new_done = 0;
            if (exp_q.size() != 0 && drv_full) mdl_full++;
            if (!busy) begin
                if (drv_valid) begin
                    n = (int'(drv_nbytes) + 7) / 8;
                    cur_id = drv_id;
                    if (n == 0) begin
                        new_done = 1; exp_done_id = drv_id;
                    end else begin
                        busy = 1;
                        for (int k = 0; k < n; k++) begin
                            s.addr    = drv_addr + 32'(k * 8);
                            s.id      = drv_id;
                            s.write   = drv_write;
                            s.sub_id  = 3'(k);
                            s.num_req = 3'(n - 1);
                            s.nbytes  = (k == n - 1) ? 7'(int'(drv_nbytes) - (n - 1) * 8) : 7'd8;
                            exp_q.push_back(s);
                        end
                    end
                end
            end else if (exp_q.size() != 0) begin
                if (!drv_full) begin
                    void'(exp_q.pop_front());
                    mdl_subs++;
                    if (exp_q.size() == 0) begin
                        if (drv_cmpl) begin
                            new_done = 1; exp_done_id = cur_id; busy = 0;
                        end else begin
                            awaiting = 1;
                        end
                    end
                end
            end else if (awaiting && drv_cmpl) begin
                new_done = 1; exp_done_id = cur_id; busy = 0; awaiting = 0;
            end
            exp_done = new_done;
        end
    endtask

    task automatic drain();
        drv_valid = 0; drv_full = 0; drv_stall = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            drv_cmpl = awaiting;
            cycle();
        end
        drv_cmpl = 0;
        cycle();
    endtask

    task automatic send(input logic [31:0] a, input logic [3:0] id, input logic wr, input logic [6:0] nb);
        drain();
        drv_addr = a; drv_id = id; drv_write = wr; drv_nbytes = nb;
        drv_valid = 1; drv_stall = 0; drv_full = 0; drv_cmpl = 0;
        cycle();
        drv_valid = 0;
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 0; prev_rst = 0;
        busy = 0; awaiting = 0; exp_done = 0; mdl_full = 0; mdl_subs = 0;
        exp_done_id = '0; cur_id = '0;
        drv_rst = 1; drv_valid = 0; drv_write = 0; drv_full = 0; drv_stall = 0; drv_cmpl = 0;
        drv_addr = '0; drv_id = '0; drv_nbytes = '0;
        repeat (2) cycle();
        drv_rst = 0;
        cycle();

        send(32'h0000_1000, 4'h5, 1'b0, 7'd24);
        drain();
        send(32'h0000_2000, 4'h6, 1'b1, 7'd13);
        drain();
        send(32'h0000_3000, 4'h7, 1'b0, 7'd64);
        drain();

        send(32'h0000_4000, 4'h8, 1'b1, 7'd24);
        cycle();
        drv_full = 1;
        repeat (4) cycle();
        drv_full = 0;
        drain();

        send(32'h0000_5000, 4'h9, 1'b0, 7'd32);
        drv_stall = 1;
        repeat (3) cycle();
        drv_stall = 0;
        for (int i = 0; i < 20 && !awaiting; i++) cycle();
        drv_stall = 1; drv_cmpl = 1;
        cycle();
        drv_cmpl = 0;
        cycle();
        drv_stall = 0;
        repeat (2) cycle();
        drain();

        send(32'hFFFF_FFF8, 4'hA, 1'b1, 7'd16);
        drain();
        send(32'h0000_6000, 4'hB, 1'b0, 7'd0);
        cycle();
        cycle();

        send(32'h0000_7000, 4'hC, 1'b1, 7'd64);
        repeat (2) cycle();
        drv_rst = 1;
        cycle();
        drv_rst = 0;
        repeat (2) cycle();
        send(32'h0000_8000, 4'hD, 1'b0, 7'd40);
        drain();

        for (int i = 0; i < 3000; i++) begin
            drv_valid  = ($urandom_range(0, 1) == 1);
            drv_addr   = $urandom;
            drv_id     = 4'($urandom);
            drv_write  = 1'($urandom);
            drv_nbytes = 7'($urandom_range(0, 64));
            drv_full   = ($urandom_range(0, 9) < 3);
            drv_stall  = ($urandom_range(0, 9) < 1);
            drv_cmpl   = ($urandom_range(0, 3) == 0);
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
